// File: rtl/free_list_pkg.sv
// Shared types and sizing for the rename free list and its ROB-indexed checkpoint table.
package free_list_pkg;

   localparam int unsigned NUM_PREGS = 128;
   localparam int unsigned NUM_AREGS = 32;
   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned FL_DEPTH  = NUM_PREGS - NUM_AREGS;

   typedef logic [6:0] preg_t;
   typedef logic [4:0] rob_tag_t;

   typedef struct packed {
      logic       lap;
      logic [6:0] idx;
   } fl_ptr_t;

   // Index wraps at FL_DEPTH rather than a power of two, so the lap bit is toggled explicitly.
   function automatic fl_ptr_t fl_ptr_inc(input fl_ptr_t p);
      fl_ptr_t r;
      if (p.idx == 7'(FL_DEPTH - 1)) begin
         r.lap = ~p.lap;
         r.idx = '0;
      end else begin
         r.lap = p.lap;
         r.idx = p.idx + 7'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/free_list_if.sv
// Rename/ROB-facing signal bundle of the free list; slave is the free list itself.
interface free_list_if;
   import free_list_pkg::*;

   logic       alloc_req;
   logic       rob_write;
   rob_tag_t   rob_tag;
   preg_t      preg_new;
   logic       empty;
   logic [6:0] free_count;
   logic       valid_retired;
   preg_t      preg_old;
   logic       mispredict;
   rob_tag_t   mispredict_tag;

   modport master (
      output alloc_req, rob_write, rob_tag, valid_retired, preg_old, mispredict, mispredict_tag,
      input  preg_new, empty, free_count
   );

   modport slave (
      input  alloc_req, rob_write, rob_tag, valid_retired, preg_old, mispredict, mispredict_tag,
      output preg_new, empty, free_count
   );

endinterface

// File: rtl/fl_ckpt_table.sv
// Per-ROB-entry snapshot of the free-list read pointer: one write port, one async read port.
module fl_ckpt_table
   import free_list_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     we_i,
   input  rob_tag_t waddr_i,
   input  fl_ptr_t  wdata_i,
   input  rob_tag_t raddr_i,
   output fl_ptr_t  rdata_o
);

   localparam int unsigned AW = $clog2(ROB_DEPTH);
   localparam int unsigned TW = $bits(rob_tag_t);

   fl_ptr_t snap_q [ROB_DEPTH];

   // The tag's upper bit is the ROB wrap bit; only the entry index selects a snapshot.
   logic [2*(TW-AW)-1:0] tag_hi_unused;
   assign tag_hi_unused = {waddr_i[TW-1:AW], raddr_i[TW-1:AW]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            snap_q[i] <= '0;
         end
      end else if (we_i) begin
         snap_q[waddr_i[AW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = snap_q[raddr_i[AW-1:0]];

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers with single-cycle mispredict recovery of the read pointer.
module free_list
   import free_list_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   free_list_if.slave fl
);

   preg_t      mem_q [FL_DEPTH];
   fl_ptr_t    rd_q, rd_d;
   fl_ptr_t    wr_q, wr_d;
   fl_ptr_t    snap_rd;
   logic [7:0] cnt;
   logic       alloc, free_req, free_ok, snap_we;

   // Computed one bit wider than the port so an overflow or underflow stays visible.
   always_comb begin
      if (rd_q.lap == wr_q.lap) begin
         cnt = {1'b0, wr_q.idx} - {1'b0, rd_q.idx};
      end else begin
         cnt = 8'(FL_DEPTH) - {1'b0, rd_q.idx} + {1'b0, wr_q.idx};
      end
   end

   assign fl.free_count = cnt[6:0];
   assign fl.empty      = (cnt == '0);
   assign fl.preg_new   = mem_q[rd_q.idx];

   assign alloc    = fl.alloc_req & ~fl.empty & ~fl.mispredict;
   assign free_req = fl.valid_retired & (fl.preg_old != '0);
   assign free_ok  = free_req & (cnt != 8'(FL_DEPTH));
   assign snap_we  = fl.rob_write & ~fl.mispredict;

   always_comb begin
      rd_d = rd_q;
      wr_d = wr_q;
      if (fl.mispredict) begin
         rd_d = snap_rd;
      end else if (alloc) begin
         rd_d = fl_ptr_inc(rd_q);
      end
      if (free_ok) begin
         wr_d = fl_ptr_inc(wr_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q <= '{lap: 1'b0, idx: '0};
         wr_q <= '{lap: 1'b1, idx: '0};
         for (int unsigned i = 0; i < FL_DEPTH; i++) begin
            mem_q[i] <= preg_t'(NUM_AREGS + i);
         end
      end else begin
         rd_q <= rd_d;
         wr_q <= wr_d;
         if (free_ok) begin
            mem_q[wr_q.idx] <= fl.preg_old;
         end
      end
   end

   // Snapshot captures the post-update pointer, so it includes this cycle's allocation.
   fl_ckpt_table u_ckpt (
      .clk     (clk),
      .reset   (reset),
      .we_i    (snap_we),
      .waddr_i (fl.rob_tag),
      .wdata_i (rd_d),
      .raddr_i (fl.mispredict_tag),
      .rdata_o (snap_rd)
   );

   a_no_free_when_full: assert property (@(posedge clk) disable iff (!reset)
      !(free_req && (cnt == 8'(FL_DEPTH))));

   a_count_in_range: assert property (@(posedge clk) disable iff (!reset)
      cnt <= 8'(FL_DEPTH));

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic against an allocation/free counter model.
module tb_free_list;
   import free_list_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   free_list_if fl_if ();

   free_list dut (
      .clk   (clk),
      .reset (reset),
      .fl    (fl_if)
   );

   int checks = 0;
   int errors = 0;

   // Model: total allocations and total frees as unbounded counters; list position = counter mod depth.
   int unsigned m_alloc;
   int unsigned m_freed;
   int unsigned m_snap [ROB_DEPTH];
   int unsigned m_mem  [FL_DEPTH];
   bit          m_valid = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_count();
      return int'(m_freed - m_alloc);
   endfunction

   task automatic model_reset();
      m_alloc = 0;
      m_freed = FL_DEPTH;
      for (int i = 0; i < int'(ROB_DEPTH); i++) m_snap[i] = 0;
      for (int i = 0; i < int'(FL_DEPTH); i++) m_mem[i] = NUM_AREGS + i;
   endtask

   task automatic model_step();
      int          cnt;
      int unsigned na;
      cnt = m_count();
      na  = m_alloc;
      if (fl_if.mispredict) na = m_snap[int'(fl_if.mispredict_tag)];
      else if (fl_if.alloc_req && cnt > 0) na = m_alloc + 1;
      if (fl_if.rob_write && !fl_if.mispredict) m_snap[int'(fl_if.rob_tag)] = na;
      if (fl_if.valid_retired && fl_if.preg_old != '0) begin
         m_mem[m_freed % FL_DEPTH] = int'(fl_if.preg_old);
         m_freed++;
      end
      m_alloc = na;
   endtask

   task automatic cyc(input bit ar, input bit rw, input int tag, input bit vr, input int po,
                      input bit mp, input int mt);
      fl_if.alloc_req      = ar;
      fl_if.rob_write      = rw;
      fl_if.rob_tag        = rob_tag_t'(tag);
      fl_if.valid_retired  = vr;
      fl_if.preg_old       = preg_t'(po);
      fl_if.mispredict     = mp;
      fl_if.mispredict_tag = rob_tag_t'(mt);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      fl_if.alloc_req      = 1'b0;
      fl_if.rob_write      = 1'b0;
      fl_if.rob_tag        = '0;
      fl_if.valid_retired  = 1'b0;
      fl_if.preg_old       = '0;
      fl_if.mispredict     = 1'b0;
      fl_if.mispredict_tag = '0;
   endtask

   task automatic chk_reset_vals(input string tagname);
      chk({tagname, " preg_new"},   int'(fl_if.preg_new),   32);
      chk({tagname, " free_count"}, int'(fl_if.free_count), 96);
      chk({tagname, " empty"},      int'(fl_if.empty),      0);
   endtask

   always @(negedge clk) begin
      if (reset && m_valid) begin
         chk("cmp free_count", int'(fl_if.free_count), m_count());
         chk("cmp empty", int'(fl_if.empty), (m_count() == 0) ? 1 : 0);
         if (m_count() != 0)
            chk("cmp preg_new", int'(fl_if.preg_new), int'(m_mem[m_alloc % FL_DEPTH]));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          ar, rw, vr, mp;
      int          tag, po, mt, pa, pf, fadd;
      int unsigned s;

      idle_inputs();
      model_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      #2 chk_reset_vals("in reset");
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b1;
      m_valid = 1'b1;

      repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
      chk_reset_vals("idle");

      for (int i = 0; i < 3; i++) begin
         chk("alloc seq", int'(fl_if.preg_new), 32 + i);
         cyc(1, 1, i, 0, 0, 0, 0);
      end
      chk("after 3 allocs preg_new", int'(fl_if.preg_new), 35);
      chk("after 3 allocs count", int'(fl_if.free_count), 93);

      cyc(0, 0, 0, 1, 5, 0, 0);
      chk("retire p5 count", int'(fl_if.free_count), 94);
      cyc(0, 0, 0, 1, 0, 0, 0);
      chk("retire p0 count", int'(fl_if.free_count), 94);

      cyc(0, 1, 3, 0, 0, 0, 0);
      chk("tag4 preg_new", int'(fl_if.preg_new), 35);
      cyc(1, 1, 4, 0, 0, 0, 0);
      chk("tag5 preg_new", int'(fl_if.preg_new), 36);
      cyc(1, 1, 5, 0, 0, 0, 0);
      chk("pre-mispredict count", int'(fl_if.free_count), 92);
      cyc(0, 0, 0, 0, 0, 1, 3);
      chk("mispredict preg_new", int'(fl_if.preg_new), 35);
      chk("mispredict count", int'(fl_if.free_count), 94);

      for (int i = 0; i < 94; i++) begin
         if (i == 93) chk("94th alloc", int'(fl_if.preg_new), 5);
         cyc(1, 0, 0, 0, 0, 0, 0);
      end
      chk("drained empty", int'(fl_if.empty), 1);
      chk("drained count", int'(fl_if.free_count), 0);

      cyc(1, 0, 0, 1, 9, 0, 0);
      chk("empty free count", int'(fl_if.free_count), 1);
      chk("empty free preg_new", int'(fl_if.preg_new), 9);

      for (int i = 0; i < 49; i++) cyc(0, 0, 0, 1, 40 + i, 0, 0);
      chk("count 50", int'(fl_if.free_count), 50);
      cyc(1, 0, 0, 1, 9, 0, 0);
      chk("alloc+free count", int'(fl_if.free_count), 50);

      cyc(0, 1, 7, 0, 0, 0, 0);
      cyc(1, 1, 8, 0, 0, 0, 0);
      cyc(1, 1, 9, 0, 0, 0, 0);
      chk("before mp+alloc", int'(fl_if.free_count), 48);
      cyc(1, 1, 10, 0, 0, 1, 7);
      chk("mp+alloc count", int'(fl_if.free_count), 50);

      for (int n = 0; n < 3000; n++) begin
         case ((n / 200) % 3)
            0:       begin pa = 80; pf = 30; end
            1:       begin pa = 30; pf = 80; end
            default: begin pa = 50; pf = 50; end
         endcase
         ar  = ($urandom_range(0, 99) < pa);
         vr  = ($urandom_range(0, 99) < pf);
         po  = vr ? int'($urandom_range(0, 127)) : 0;
         if (vr && po != 0 && m_count() == 96) vr = 1'b0;
         rw  = ($urandom_range(0, 99) < 50);
         tag = int'($urandom_range(0, ROB_DEPTH - 1));
         mp  = ($urandom_range(0, 99) < 4);
         mt  = int'($urandom_range(0, ROB_DEPTH - 1));
         if (mp) begin
            fadd = (vr && po != 0) ? 1 : 0;
            s    = m_snap[mt];
            if (s > m_alloc || (m_freed + fadd - s) > FL_DEPTH) mp = 1'b0;
         end
         cyc(ar, rw, tag, vr, po, mp, mt);
      end

      #2 reset = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 96; i++) begin
         chk("wrap alloc", int'(fl_if.preg_new), 32 + i);
         cyc(1, 0, 0, 0, 0, 0, 0);
      end
      chk("wrap empty", int'(fl_if.empty), 1);
      for (int i = 0; i < 96; i++) cyc(0, 0, 0, 1, 127 - i, 0, 0);
      chk("wrap full count", int'(fl_if.free_count), 96);
      chk("wrap full empty", int'(fl_if.empty), 0);
      for (int i = 0; i < 96; i++) begin
         chk("wrap order", int'(fl_if.preg_new), 127 - i);
         cyc(1, 0, 0, 0, 0, 0, 0);
      end

      for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 50 + i, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0);
      fl_if.alloc_req = 1'b1;
      #2 reset = 1'b0;
      #1 chk_reset_vals("async reset");
      idle_inputs();
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
      chk_reset_vals("post reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register numbers between the rename stage and the ROB.
- Rename pops one preg per renamed instruction that has a destination register.
- The ROB returns preg_old on each retire (valid_retired).
- Each ROB allocation snapshots the free-list read pointer, indexed by ROB tag. A mispredict then restores the read pointer, so every preg allocated younger than the branch is reclaimed in one cycle.

Parameters:
- NUM_PREGS, 128, total physical registers; preg width is 7 bits.
- NUM_AREGS, 32, architectural registers; p0..p31 hold the initial mapping and are not in the list at reset.
- ROB_DEPTH, 16, ROB entries; the ROB tag is 5 bits.
- FL_DEPTH, NUM_PREGS-NUM_AREGS = 96, free-list capacity.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- alloc_req  in  1  rename pops one preg this cycle.
- rob_write  in  1  an instruction is allocated into the ROB this cycle (same as the ROB write_en).
- rob_tag  in  5  ROB tag being allocated this cycle (the ROB ptr).
- preg_new  out  7  head-of-list preg, valid when empty=0.
- empty  out  1  no free pregs.
- free_count  out  7  number of free entries, 0..96.
- valid_retired  in  1  ROB retire pulse.
- preg_old  in  7  preg freed on retire.
- mispredict  in  1  recovery pulse from the ROB.
- mispredict_tag  in  5  ROB tag of the mispredicted branch.

Behaviour:
- Storage:
  - mem[0..95] of 7-bit entries.
  - rd_ptr and wr_ptr: 7-bit index, range 0..95, each with a lap bit.
  - Increment wraps 95->0 and toggles the lap bit.
- Counting:
  - free_count = wr_idx - rd_idx when the lap bits are equal, else 96 - rd_idx + wr_idx.
  - empty = (free_count == 0).
  - Both are combinational from registered pointers.
- preg_new = mem[rd_idx], combinational; zero latency from pointer update.
- Reset (async, reset=0):
  - mem[i] = NUM_AREGS + i.
  - rd = {lap 0, idx 0}, wr = {lap 1, idx 0}; the list is full.
  - free_count = 96, empty = 0, preg_new = 32.
  - All snapshots = {0, 0}.
  - Reset mid-operation discards all state immediately.
- Allocate: at the clock edge, if alloc_req & !empty & !mispredict, rd_ptr advances by 1.
  - alloc_req with empty=1 is ignored; rename must stall.
- Snapshot:
  - If rob_write & !mispredict, snap[rob_tag] <= the post-update rd_ptr for this cycle (including this cycle's alloc).
  - Snapshots are taken even when alloc_req = 0, e.g. for branches and stores.
- Free:
  - If valid_retired & preg_old != 0: mem[wr_idx] <= preg_old, and wr_ptr advances by 1.
  - p0 is pinned and never freed.
  - A free while free_count == 96 is an illegal upstream condition: ignore it and fire a simulation assertion.
- Mispredict: rd_ptr <= snap[mispredict_tag] at the edge.
  - Alloc and snapshot writes in the same cycle are dropped.
  - A free in the same cycle still completes, because retirement is older than the branch.
- Simultaneous alloc+free in one cycle:
  - Both happen; free_count is unchanged.
  - When empty=1, a same-cycle free does not bypass to preg_new; the freed preg is visible next cycle.
- free_count never exceeds 96 nor underflows; assert this in simulation.

Decomposition:
- The shared types_pkg gains:
  - localparams NUM_PREGS, NUM_AREGS, FL_DEPTH.
  - typedef preg_t (logic [6:0]).
  - typedef rob_tag_t (logic [4:0]).
  - typedef fl_ptr_t (struct {logic lap; logic [6:0] idx;}).
- Sub-module fl_ckpt_table: a ROB_DEPTH x fl_ptr_t register file with one write port and one async read port. Keep the pointer/FIFO logic in free_list.

Test Plan:
- Reset, then 3 cycles idle -> preg_new = 32, free_count = 96, empty = 0; the pointers do not move.
- Alloc 3 times with rob_write at tags 0,1,2 -> preg_new sequence is 32, 33, 34; the final preg_new is 35 and free_count = 93.
- Retire preg_old = 5, then preg_old = 0 -> free_count goes 93 -> 94 -> 94, since p0 is ignored. Drain 94 more allocs to reach empty=1: the 94th alloc returns p5.
- Alloc at tags 3 (branch, no alloc), 4, 5 (alloc p35, p36); mispredict tag 3 -> preg_new = 35 next cycle and free_count restored to its value after tag 3.
- Same-cycle alloc_req + valid_retired (preg_old = 9) at free_count = 50 -> free_count stays 50, rd and wr each advance by 1. Same-cycle mispredict + alloc_req -> alloc dropped, rd = snapshot.
- Wrap: after 96 allocs and 96 frees -> rd and wr lap bits both toggle, free_count = 96, and mem order is preserved. Assert reset=0 mid-burst -> outputs return to reset values asynchronously.
